// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and constants for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arb_state_t;
  localparam logic [3:0] FULL_MASK = 4'b1111;
endpackage

// File: rtl/arb_grant.sv
// arb_grant: two-way fetch/data grant with priority pointer (round robin under MEM_ARB_ROUND_ROBIN_EN).
module arb_grant (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic gnt_if,
  output logic gnt_dm
);
  logic ptr;
  // ptr=0 favours DM on a tie; in fixed mode it never leaves DM.
  assign gnt_dm = dm_req & (~if_req | ~ptr);
  assign gnt_if = if_req & ~gnt_dm;
  always_ff @(posedge clk)
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr <= rst ? 1'b0 : (en & (gnt_dm | gnt_if)) ? gnt_dm : ptr;
`else
    ptr <= 1'b0;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction outstanding.
// Round-robin tie breaking is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_request,
  input  logic [ADDRESS-1:0] if_addr,
  output logic               if_valid,
  output logic [DATA-1:0]    if_rdata,
  output logic               if_stall,
  input  logic               dm_request,
  input  logic               dm_we_re,
  input  logic [3:0]         dm_mask,
  input  logic [ADDRESS-1:0] dm_addr,
  input  logic [DATA-1:0]    dm_wdata,
  output logic               dm_valid,
  output logic [DATA-1:0]    dm_rdata,
  output logic               mem_request,
  output logic               mem_we_re,
  output logic [3:0]         mem_mask,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [DATA-1:0]    mem_wdata,
  input  logic               mem_valid,
  input  logic [DATA-1:0]    mem_rdata
);
  arb_state_t state, next;
  logic gnt_if, gnt_dm, own_if, own_dm;
  arb_grant u_grant (
    .clk    (clk),
    .rst    (rst),
    .en     (state == IDLE),
    .if_req (if_request),
    .dm_req (dm_request),
    .gnt_if (gnt_if),
    .gnt_dm (gnt_dm)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  // Ownership is masked by rst so a response arriving during reset never strobes.
  always_comb begin
    next        = (state == IDLE) ? (gnt_dm ? DM_BUSY : gnt_if ? IF_BUSY : IDLE)
                                  : (mem_valid ? IDLE : state);
    own_if      = ~rst & (state == IF_BUSY);
    own_dm      = ~rst & (state == DM_BUSY);
    mem_request = own_if | own_dm;
    mem_we_re   = own_dm & dm_we_re;
    mem_mask    = own_dm ? dm_mask : own_if ? FULL_MASK : '0;
    mem_addr    = own_dm ? dm_addr : own_if ? if_addr : '0;
    mem_wdata   = own_dm ? dm_wdata : '0;
    if_valid    = own_if & mem_valid;
    dm_valid    = own_dm & mem_valid;
    if_rdata    = if_valid ? mem_rdata : '0;
    dm_rdata    = dm_valid ? mem_rdata : '0;
    if_stall    = ~rst & if_request & (state != IF_BUSY);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_request, dm_request, dm_we_re, mem_valid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_mask;
  logic        if_valid, if_stall, dm_valid, mem_request, mem_we_re;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  int total = 0;
  int bad = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_addr(if_addr), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_request(dm_request), .dm_we_re(dm_we_re), .dm_mask(dm_mask),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_request = 1'b1; dm_request = 1'b1; dm_we_re = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_mask = 4'h0;
    mem_valid = 1'b0; mem_rdata = 32'h0;
    // reset with both requests high
    step(); step(); #1;
    chk("rst_mem_req", mem_request, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_mask", mem_mask, 0);
    chk("rst_stall", if_stall, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    rst = 1'b0; if_request = 1'b0; dm_request = 1'b0;
    step();
    // single fetch, memory answers on the third busy cycle
    if_request = 1'b1; if_addr = 32'h40; #1;
    chk("if_stall_idle", if_stall, 1);
    step(); #1;
    chk("if_mem_req", mem_request, 1);
    chk("if_mem_addr", mem_addr, 32'h40);
    chk("if_mem_mask", mem_mask, 4'hF);
    chk("if_mem_we", mem_we_re, 0);
    chk("if_stall_busy", if_stall, 0);
    step(); step(); #1;
    chk("if_wait_valid", if_valid, 0);
    mem_valid = 1'b1; mem_rdata = 32'h0050_0093; #1;
    chk("if_valid", if_valid, 1);
    chk("if_rdata", if_rdata, 32'h0050_0093);
    chk("if_no_dm_valid", dm_valid, 0);
    step(); mem_valid = 1'b0; if_request = 1'b0; #1;
    chk("if_idle_req", mem_request, 0);
    chk("if_idle_valid", if_valid, 0);
    // collision: DM first, IF after one idle bubble
    dm_request = 1'b1; dm_we_re = 1'b0; dm_addr = 32'h100; dm_mask = 4'hF;
    if_request = 1'b1; if_addr = 32'h44; #1;
    chk("col_stall0", if_stall, 1);
    step(); #1;
    chk("col_dm_addr", mem_addr, 32'h100);
    chk("col_stall1", if_stall, 1);
    mem_valid = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("col_dm_valid", dm_valid, 1);
    chk("col_dm_rdata", dm_rdata, 32'h1234_5678);
    chk("col_if_valid0", if_valid, 0);
    chk("col_stall2", if_stall, 1);
    step(); mem_valid = 1'b0; dm_request = 1'b0; #1;
    chk("col_bubble_req", mem_request, 0);
    chk("col_bubble_stall", if_stall, 1);
    step(); #1;
    chk("col_if_addr", mem_addr, 32'h44);
    chk("col_if_stall", if_stall, 0);
    mem_valid = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    chk("col_if_valid", if_valid, 1);
    chk("col_if_rdata", if_rdata, 32'hCAFE_0001);
    step(); mem_valid = 1'b0; if_request = 1'b0;
    // store
    dm_request = 1'b1; dm_we_re = 1'b1; dm_mask = 4'b0011;
    dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h200;
    step(); #1;
    chk("st_req", mem_request, 1);
    chk("st_we", mem_we_re, 1);
    chk("st_mask", mem_mask, 4'b0011);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_wait", dm_valid, 0);
    step(); mem_valid = 1'b1; #1;
    chk("st_valid", dm_valid, 1);
    step(); mem_valid = 1'b0; dm_request = 1'b0; dm_we_re = 1'b0; #1;
    chk("st_valid_once", dm_valid, 0);
    chk("st_idle_we", mem_we_re, 0);
    // reset mid-transaction, then a stray response
    dm_request = 1'b1; dm_addr = 32'h300; dm_mask = 4'hF;
    step(); #1;
    chk("rm_busy", mem_request, 1);
    rst = 1'b1;
    step(); rst = 1'b0; dm_request = 1'b0; mem_valid = 1'b1; #1;
    chk("rm_no_valid", dm_valid, 0);
    chk("rm_req_low", mem_request, 0);
    step(); mem_valid = 1'b0; #1;
    chk("rm_stay_idle", mem_request, 0);
    // both requests held for four transactions
    dm_request = 1'b1; dm_we_re = 1'b0; dm_addr = 32'h100; if_request = 1'b1; if_addr = 32'h44;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_addr = (i % 2 == 1) ? 32'h44 : 32'h100;
`else
      exp_addr = 32'h100;
`endif
      step(); #1;
      chk($sformatf("rr_owner%0d", i), mem_addr, exp_addr);
      mem_valid = 1'b1; #1;
      chk($sformatf("rr_valid%0d", i), {if_valid, dm_valid}, (exp_addr == 32'h44) ? 2'b10 : 2'b01);
      step(); mem_valid = 1'b0; #1;
      chk($sformatf("rr_bubble%0d", i), mem_request, 0);
    end
    dm_request = 1'b0; if_request = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single core memory port between the instruction-fetch requester and the data-memory (load/store) requester. It sits between the fetch stage / load-store unit and the unified memory interface. It holds at most one transaction outstanding, routes the response back to the owner, and raises a fetch-stall indication whenever fetch is waiting behind a data access.

## Interface
Parameters:
- `ADDRESS`, default 32: address width.
- `DATA`, default 32: data width.

Ports:
- `clk`  in  1  clock. One clock domain; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_request`  in  1  fetch request. Level signal, held until `if_valid`.
- `if_addr`  in  ADDRESS  fetch address. Stable while `if_request` is high.
- `if_valid`  out  1  fetch response strobe, one cycle.
- `if_rdata`  out  DATA  fetched instruction. Meaningful only when `if_valid` is high.
- `if_stall`  out  1  high while `if_request` is high and fetch does not own the port.
- `dm_request`  in  1  data request. Level signal, held until `dm_valid`.
- `dm_we_re`  in  1  1 = write, 0 = read.
- `dm_mask`  in  4  byte enables.
- `dm_addr`  in  ADDRESS  data address.
- `dm_wdata`  in  DATA  store data.
- `dm_valid`  out  1  data response strobe, one cycle.
- `dm_rdata`  out  DATA  load data.
- `mem_request`  out  1  memory request. High for the whole transaction.
- `mem_we_re`  out  1  memory write/read select.
- `mem_mask`  out  4  memory byte enables.
- `mem_addr`  out  ADDRESS  memory address.
- `mem_wdata`  out  DATA  memory write data.
- `mem_valid`  in  1  memory completion strobe. Latency is variable, at least 1 cycle.
- `mem_rdata`  in  DATA  memory read data.

## Operation
FSM states are IDLE, IF_BUSY and DM_BUSY.
- **IDLE**
  - `dm_request` high → DM_BUSY.
  - Else `if_request` high → IF_BUSY.
  - Fixed priority: data beats fetch.
  - Request inputs are sampled in IDLE only.
- **IF_BUSY**
  - Drives `mem_request=1`, `mem_we_re=0`, `mem_mask=4'b1111`, `mem_addr=if_addr`.
  - On `mem_valid`: `if_valid=1`, `if_rdata=mem_rdata` (combinational pass-through), next state IDLE.
- **DM_BUSY**
  - Drives `mem_request=1` plus the `dm_*` fields onto `mem_*`.
  - On `mem_valid`: `dm_valid=1`, `dm_rdata=mem_rdata`, next state IDLE.
  - A write still returns `dm_valid`; `dm_rdata` is don't-care.
- **IDLE outputs:** all `mem_*` outputs are 0.
- **Requester duty:** each requester must deassert, or present a new transaction, in the cycle after its valid. A request still high in IDLE is served again.
- **Stray responses:** `mem_valid` in IDLE is ignored and produces no valid strobe.
- **Inputs mid-transaction:** the owner's inputs are passed through combinationally. Changing them mid-transaction is a protocol violation. Output is unspecified, but the FSM must not hang.
- **`if_stall`:** `if_request & (state != IF_BUSY)`.

## Timing
- **Reset values:** state IDLE; all outputs 0; priority pointer = DM.
- **Latency:** request seen in IDLE at cycle 0 → `mem_request` high at cycle 1 → valid in the same cycle as `mem_valid`.
  - Minimum turnaround is 2 cycles.
  - One IDLE bubble separates consecutive transactions.
- **Simultaneous requests in IDLE:** DM is granted; IF is granted after DM completes.
- **Reset mid-transaction:** returns to IDLE at the next edge. `mem_request` drops and any pending response is discarded.
- **Reset while `mem_valid` is high:** no valid strobe is emitted.

## Configuration
Macro `MEM_ARB_ROUND_ROBIN_EN`:
- **Undefined:** fixed DM priority as described above. Fetch can starve under continuous data traffic.
- **Defined:** a 1-bit priority pointer resolves simultaneous requests.
  - The pointer flips to the other requester after each grant.
  - Ties alternate DM, IF, DM, …
  - A lone requester is always granted, whatever the pointer says.
  - The pointer resets to DM.

## Structure
- **Shared package `mem_arb_pkg`:**
  - `typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arb_state_t`.
  - Constant `FULL_MASK = 4'b1111`.
- **Sub-module `arb_grant`:** combinational two-way grant logic (fixed or round-robin) plus the priority-pointer register.
- **Top module:** keeps the FSM and the muxing.

## Test plan
- **Reset:**
  - Drive `rst=1` for 2 cycles with both requests high.
  - Expect all outputs 0 and no valid strobe.
- **Single fetch:**
  - `if_request=1`, `if_addr=0x0000_0040`; memory returns `mem_valid` 3 cycles later with `mem_rdata=0x0050_0093`.
  - Expect `mem_addr=0x40` and `mem_mask=4'hF`, then `if_valid` with `if_rdata=0x0050_0093`.
  - Expect `if_stall=0` only while in IF_BUSY.
- **Collision:**
  - Drive `dm_request` (read at `0x100`) and `if_request` (`0x44`) in the same cycle.
  - Expect DM served first and `if_stall=1` throughout.
  - Expect the IF grant in the cycle after the IDLE bubble.
- **Store:**
  - `dm_we_re=1`, `dm_mask=4'b0011`, `dm_wdata=0xDEAD_BEEF` at `0x200`.
  - Expect `mem_*` to mirror these values and `dm_valid` one cycle with `mem_valid`.
- **Reset mid-transaction:**
  - Assert `rst` in DM_BUSY, then deliver `mem_valid` on the next cycle.
  - Expect no `dm_valid`, state IDLE and `mem_request=0`.
- **Round robin (`MEM_ARB_ROUND_ROBIN_EN`):**
  - Hold both requests continuously for 4 transactions.
  - Expect the grant order DM, IF, DM, IF.
  - Without the macro, expect DM on all four.
